// File: rtl/spi_cmd_regfile_if.sv
// Word-level link between the SPI slave driver and its register-file back end.
// The driver side is the master: it presents cmd/data and the frame pulses and takes Din back.
interface spi_cmd_regfile_if #(
    parameter int width_cmd  = 8,
    parameter int width_data = 16
);
    logic [width_cmd-1:0]  Dcmd;
    logic [width_data-1:0] Dout;
    logic                  begin_data;
    logic                  end_data;
    logic [width_data-1:0] Din;

    modport master (output Dcmd, Dout, begin_data, end_data, input Din);
    modport slave  (input Dcmd, Dout, begin_data, end_data, output Din);
endinterface

// File: rtl/spi_cmd_regfile.sv
// Register file behind the SPI slave driver: RW control words, RO status words and an ID word,
// with write/read strobes toward the fabric and a sticky protocol error flag.
module spi_cmd_regfile #(
    parameter int                  width_cmd  = 8,
    parameter int                  width_data = 16,
    parameter int                  NUM_RW     = 8,
    parameter int                  NUM_RO     = 4,
    parameter int                  ID_ADDR    = 127,
    parameter logic [width_data-1:0] ID_VALUE = 16'hA55A
) (
    input  logic                           clk,
    input  logic                           rst,
    spi_cmd_regfile_if.slave               bus,
    input  logic [NUM_RO*width_data-1:0]   status_in,
    output logic [NUM_RW*width_data-1:0]   ctrl_out,
    output logic                           wr_strobe,
    output logic [width_cmd-2:0]           wr_addr,
    output logic                           rd_strobe,
    output logic [width_cmd-2:0]           rd_addr,
    output logic [7:0]                     frame_cnt,
    output logic                           err
);
    // state  | meaning
    // IDLE   | waiting for begin_data
    // ACTIVE | data frame in flight, Din frozen
    // COMMIT | one cycle after end_data, wr_strobe window
    typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

    localparam int AW = width_cmd - 1;

    state_t                               state_q, state_d;
    logic [width_cmd-1:0]                 cmd_q, cmd_d;
    logic [NUM_RW-1:0][width_data-1:0]    ctrl_q, ctrl_d;
    logic [NUM_RO-1:0][width_data-1:0]    status_w;
    logic [width_data-1:0]                din_q, din_d, din_sel;
    logic                                 wr_strobe_q, wr_strobe_d;
    logic                                 rd_strobe_q, rd_strobe_d;
    logic [AW-1:0]                        wr_addr_q, wr_addr_d;
    logic [AW-1:0]                        rd_addr_q, rd_addr_d;
    logic [7:0]                           frame_cnt_q, frame_cnt_d;
    logic                                 err_q, err_d;
    logic [AW-1:0]                        cur_addr, cmd_addr;
    logic                                 cmd_is_wr;

    assign status_w  = status_in;
    assign cur_addr  = bus.Dcmd[AW-1:0];
    assign cmd_addr  = cmd_q[AW-1:0];
    assign cmd_is_wr = cmd_q[width_cmd-1];

    always_comb begin
        din_sel = '0;
        for (int k = 0; k < NUM_RW; k++)
            if (int'(cur_addr) == k) din_sel = ctrl_q[k];
        for (int k = 0; k < NUM_RO; k++)
            if (int'(cur_addr) == NUM_RW + k) din_sel = status_w[k];
        if (int'(cur_addr) == ID_ADDR) din_sel = ID_VALUE;
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ctrl_d      = ctrl_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        // Hold the transmit word while the frame shifts out, whatever the MCU writes meanwhile.
        din_d       = (state_q == ACTIVE) ? din_q : din_sel;

        if (bus.end_data) begin
            if (state_q == ACTIVE) begin
                state_d     = COMMIT;
                frame_cnt_d = frame_cnt_q + 8'd1;
                if (cmd_is_wr) begin
                    if (int'(cmd_addr) < NUM_RW) begin
                        for (int k = 0; k < NUM_RW; k++)
                            if (int'(cmd_addr) == k) ctrl_d[k] = bus.Dout;
                        wr_addr_d   = cmd_addr;
                        wr_strobe_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end else begin
                err_d = 1'b1;
                if (state_q == COMMIT) state_d = IDLE;
            end
        end else begin
            if (state_q == COMMIT) state_d = IDLE;
            if (bus.begin_data) begin
                if (state_q == ACTIVE) err_d = 1'b1;
                state_d = ACTIVE;
                cmd_d   = bus.Dcmd;
                if (!bus.Dcmd[width_cmd-1]) begin
                    rd_strobe_d = 1'b1;
                    rd_addr_d   = cur_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            ctrl_q      <= '0;
            din_q       <= '0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ctrl_q      <= ctrl_d;
            din_q       <= din_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.Din   = din_q;
    assign ctrl_out  = ctrl_q;
    assign wr_strobe = wr_strobe_q;
    assign rd_strobe = rd_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;
endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed bench for spi_cmd_regfile: strobes are checked by a scoreboard monitor,
// register/Din/err/frame count values by directed checks against hand-computed constants.
module tb_spi_cmd_regfile;
    logic         clk, rst;
    logic [63:0]  status_in;
    logic [127:0] ctrl_out;
    logic         wr_strobe, rd_strobe, err;
    logic [6:0]   wr_addr, rd_addr;
    logic [7:0]   frame_cnt;

    spi_cmd_regfile_if bus_if ();

    spi_cmd_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .rd_strobe (rd_strobe),
        .rd_addr   (rd_addr),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
        logic [7:0]  fcnt;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [6:0] rd_q[$];
    wr_exp_t    wr_e;
    logic [6:0] rd_e;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_cnt;
    logic [127:0] exp_ctrl;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe) begin
                if (wr_q.size() == 0) begin
                    chk("wr_strobe_unexpected", 128'(wr_strobe), 128'd0);
                end else begin
                    wr_e = wr_q.pop_front();
                    chk("wr_addr", 128'(wr_addr), 128'(wr_e.addr));
                    chk("wr_ctrl_word", 128'(ctrl_out[int'(wr_e.addr)*16 +: 16]), 128'(wr_e.data));
                    chk("wr_frame_cnt", 128'(frame_cnt), 128'(wr_e.fcnt));
                end
            end
            if (rd_strobe) begin
                if (rd_q.size() == 0) begin
                    chk("rd_strobe_unexpected", 128'(rd_strobe), 128'd0);
                end else begin
                    rd_e = rd_q.pop_front();
                    chk("rd_addr", 128'(rd_addr), 128'(rd_e));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge with the FSM in IDLE; returns at a negedge back in IDLE.
    task automatic frame(input logic [7:0] cmd, input logic [15:0] dout, input bit exp_wr);
        bus_if.Dcmd = cmd;
        bus_if.Dout = dout;
        @(negedge clk);
        if (!cmd[7]) rd_q.push_back(cmd[6:0]);
        bus_if.begin_data = 1'b1;
        @(negedge clk);
        bus_if.begin_data = 1'b0;
        @(negedge clk);
        exp_cnt++;
        if (exp_wr) wr_q.push_back('{addr: cmd[6:0], data: dout, fcnt: exp_cnt});
        bus_if.end_data = 1'b1;
        @(negedge clk);
        bus_if.end_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus_if.Dcmd = 8'h00;
        bus_if.Dout = 16'h0000;
        bus_if.begin_data = 1'b0;
        bus_if.end_data = 1'b0;
        status_in = {16'h4444, 16'h3333, 16'hBEEF, 16'h1111};
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset asserted in the middle of a write frame
        bus_if.Dcmd = 8'h85;
        bus_if.Dout = 16'hDEAD;
        @(negedge clk);
        bus_if.begin_data = 1'b1;
        @(negedge clk);
        bus_if.begin_data = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl_out", ctrl_out, 128'd0);
        chk("rst_din", 128'(bus_if.Din), 128'd0);
        chk("rst_wr_strobe", 128'(wr_strobe), 128'd0);
        chk("rst_rd_strobe", 128'(rd_strobe), 128'd0);
        chk("rst_frame_cnt", 128'(frame_cnt), 128'd0);
        chk("rst_err", 128'(err), 128'd0);

        // Write 0x1234 to register 3
        frame(8'h83, 16'h1234, 1'b1);
        exp_ctrl = '0;
        exp_ctrl[48 +: 16] = 16'h1234;
        chk("write_ctrl_out", ctrl_out, exp_ctrl);
        chk("write_frame_cnt", 128'(frame_cnt), 128'd1);
        chk("write_err", 128'(err), 128'd0);

        // Read back register 3; Din must stay frozen while the frame is active
        bus_if.Dcmd = 8'h03;
        @(negedge clk);
        chk("read_din_reg3", 128'(bus_if.Din), 128'h1234);
        rd_q.push_back(7'd3);
        bus_if.begin_data = 1'b1;
        @(negedge clk);
        bus_if.begin_data = 1'b0;
        bus_if.Dcmd = 8'h7F;
        repeat (2) @(negedge clk);
        chk("din_frozen_active", 128'(bus_if.Din), 128'h1234);
        exp_cnt++;
        bus_if.end_data = 1'b1;
        @(negedge clk);
        bus_if.end_data = 1'b0;
        @(negedge clk);
        chk("read_frame_cnt", 128'(frame_cnt), 128'd2);
        chk("din_id", 128'(bus_if.Din), 128'hA55A);
        bus_if.Dcmd = 8'h09;
        @(negedge clk);
        chk("din_status1", 128'(bus_if.Din), 128'hBEEF);
        bus_if.Dcmd = 8'h0B;
        @(negedge clk);
        chk("din_status3", 128'(bus_if.Din), 128'h4444);
        frame(8'h0C, 16'h0000, 1'b0);
        chk("din_unmapped", 128'(bus_if.Din), 128'd0);
        chk("read_unmapped_err", 128'(err), 128'd0);

        // Write to an RO address is dropped and flags err
        frame(8'h88, 16'hFFFF, 1'b0);
        chk("badwr_ctrl_out", ctrl_out, exp_ctrl);
        chk("badwr_err", 128'(err), 128'd1);
        chk("badwr_frame_cnt", 128'(frame_cnt), 128'd4);

        // end_data while IDLE
        pulse_reset();
        chk("proto_err_clear", 128'(err), 128'd0);
        bus_if.end_data = 1'b1;
        @(negedge clk);
        bus_if.end_data = 1'b0;
        @(negedge clk);
        chk("idle_end_err", 128'(err), 128'd1);
        chk("idle_end_frame_cnt", 128'(frame_cnt), 128'd0);

        // Two begin_data without end_data: the second command wins
        pulse_reset();
        bus_if.Dcmd = 8'h81;
        bus_if.Dout = 16'h0000;
        bus_if.begin_data = 1'b1;
        @(negedge clk);
        bus_if.Dcmd = 8'h82;
        @(negedge clk);
        bus_if.begin_data = 1'b0;
        @(negedge clk);
        exp_cnt++;
        wr_q.push_back('{addr: 7'd2, data: 16'h5555, fcnt: exp_cnt});
        bus_if.Dout = 16'h5555;
        bus_if.end_data = 1'b1;
        @(negedge clk);
        bus_if.end_data = 1'b0;
        @(negedge clk);
        exp_ctrl = '0;
        exp_ctrl[32 +: 16] = 16'h5555;
        chk("restart_ctrl_out", ctrl_out, exp_ctrl);
        chk("restart_err", 128'(err), 128'd1);

        // frame_cnt wraps after 256 frames
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            frame(8'h00, 16'h0000, 1'b0);
            if (i == 254) chk("wrap_cnt_255", 128'(frame_cnt), 128'd255);
        end
        chk("wrap_cnt_0", 128'(frame_cnt), 128'd0);
        chk("wrap_err", 128'(err), 128'd0);

        // begin_data during the COMMIT cycle of a write
        bus_if.Dcmd = 8'h84;
        bus_if.Dout = 16'h0BAD;
        @(negedge clk);
        bus_if.begin_data = 1'b1;
        @(negedge clk);
        bus_if.begin_data = 1'b0;
        @(negedge clk);
        exp_cnt++;
        wr_q.push_back('{addr: 7'd4, data: 16'h0BAD, fcnt: exp_cnt});
        bus_if.end_data = 1'b1;
        @(negedge clk);
        bus_if.end_data = 1'b0;
        bus_if.Dcmd = 8'h04;
        rd_q.push_back(7'd4);
        bus_if.begin_data = 1'b1;
        @(negedge clk);
        bus_if.begin_data = 1'b0;
        chk("b2b_din", 128'(bus_if.Din), 128'h0BAD);
        @(negedge clk);
        exp_cnt++;
        bus_if.end_data = 1'b1;
        @(negedge clk);
        bus_if.end_data = 1'b0;
        @(negedge clk);
        chk("b2b_frame_cnt", 128'(frame_cnt), 128'd2);
        chk("b2b_err", 128'(err), 128'd0);

        repeat (3) @(negedge clk);
        chk("wr_q_drained", 128'(wr_q.size()), 128'd0);
        chk("rd_q_drained", 128'(rd_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
